gf_input_fifo: RTL and testbench

Parametrised input buffer for the hit/road stream entering the fitter. It takes words qualified by an asynchronous upstream strobe `ds`, synchronises the strobe into the `clock` domain and stores the words in an internal RAM FIFO of configurable width and depth. It drives an active-low `hold` back to the sender with programmable on/off hysteresis. It also adds event-aware overflow handling, a dropped-word counter and a spy tap.

---
 rtl/gf_fifo_pkg.sv | 25 ++
 rtl/gf_sync_edge.sv | 55 +++++
 rtl/gf_input_fifo.sv | 145 ++++++++++++++
 tb/tb_gf_input_fifo.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_fifo_pkg.sv
// Shared constants, state encoding and word-field helpers for the fitter input FIFO.
package gf_fifo_pkg;

  localparam int GF_DATA_W      = 23;
  localparam int GF_DEPTH_LOG2  = 9;
  localparam int GF_HOLD_ON     = 448;
  localparam int GF_HOLD_OFF    = 384;
  localparam int GF_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    ST_PASS = 1'b0,
    ST_DROP = 1'b1
  } gf_state_e;

  // End-event flag sits in the top bit of every stored word.
  function automatic int gf_ee_bit(input int data_w);
    return data_w - 1;
  endfunction

  // End-packet flag sits just below the end-event flag.
  function automatic int gf_ep_bit(input int data_w);
    return data_w - 2;
  endfunction

endpackage

// File: rtl/gf_sync_edge.sv
// Brings the asynchronous strobe into the clock domain, detects its rising edge and
// delays the payload so the word leaving here was captured on the same edge as sync stage 1.
module gf_sync_edge #(
  parameter int DATA_W      = 23,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ds,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_stb,
  output logic [DATA_W-1:0] word
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;
  logic                   wr_stb_q, wr_stb_d;
  logic [DATA_W-1:0]      word_q, word_d;
  logic [DATA_W-1:0]      pipe_q [SYNC_STAGES];
  logic [DATA_W-1:0]      pipe_d [SYNC_STAGES];
  logic                   wr_req;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ds};
    edge_d = sync_q[SYNC_STAGES-1];
    wr_req = sync_q[SYNC_STAGES-1] & ~edge_q;
    pipe_d[0] = data_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    // The request and its word are registered together before reaching the FIFO.
    wr_stb_d = wr_req;
    word_d   = pipe_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      pipe_q   <= '{default: '0};
      wr_stb_q <= 1'b0;
      word_q   <= '0;
    end else begin
      sync_q   <= sync_d;
      edge_q   <= edge_d;
      pipe_q   <= pipe_d;
      wr_stb_q <= wr_stb_d;
      word_q   <= word_d;
    end
  end

  assign wr_stb = wr_stb_q;
  assign word   = word_q;

endmodule

// File: rtl/gf_input_fifo.sv
// Strobe-qualified input FIFO for the fitter hit/road stream with hysteretic hold,
// event-aware overflow dropping, a saturating drop counter and a write spy tap.
//
// state   | meaning
// ------- | --------------------------------------------------------------
// ST_PASS | words are stored while space exists; a full-time word is dropped
// ST_DROP | an event overflowed; every word is dropped up to and incl. its EE word
module gf_input_fifo
  import gf_fifo_pkg::*;
#(
  parameter int DATA_W      = GF_DATA_W,
  parameter int DEPTH_LOG2  = GF_DEPTH_LOG2,
  parameter int HOLD_ON     = GF_HOLD_ON,
  parameter int HOLD_OFF    = GF_HOLD_OFF,
  parameter int SYNC_STAGES = GF_SYNC_STAGES,
  parameter bit EVT_DROP    = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ds,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_enable,
  input  logic              clear,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              empty,
  output logic              full,
  output logic              hold,
  output logic              overflow,
  output logic [15:0]       drop_count,
  output logic [DATA_W:0]   spy_data,
  output logic              spy_dv
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CW     = DEPTH_LOG2 + 1;
  localparam int EE_BIT = gf_ee_bit(DATA_W);
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] ON_C   = CW'(HOLD_ON);
  localparam logic [CW-1:0] OFF_C  = CW'(HOLD_OFF);

  logic                  wr_stb;
  logic [DATA_W-1:0]     word;

  gf_state_e             state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  valid_q, valid_d;
  logic                  hold_act_q, hold_act_d;
  logic                  overflow_q, overflow_d;
  logic [15:0]           drop_cnt_q, drop_cnt_d;

  logic                  empty_c, full_c, rd_en, wr_en, drop;
  logic [DATA_W-1:0]     mem [DEPTH];

  gf_sync_edge #(
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock   (clock),
    .reset   (reset),
    .ds      (ds),
    .data_in (data_in),
    .wr_stb  (wr_stb),
    .word    (word)
  );

  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == FULL_C);
    rd_en   = read_enable & ~empty_c;
    // Full is judged before any concurrent pop, so a full FIFO never takes a write.
    wr_en   = wr_stb & ~full_c & (state_q == ST_PASS);
    drop    = wr_stb & ~wr_en;

    wr_ptr_d = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;

    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    data_out_d = rd_en ? mem[rd_ptr_q] : data_out_q;
    valid_d    = rd_en;

    if (count_q >= ON_C)       hold_act_d = 1'b1;
    else if (count_q <= OFF_C) hold_act_d = 1'b0;
    else                       hold_act_d = hold_act_q;

    state_d = state_q;
    case (state_q)
      ST_PASS: if (EVT_DROP && wr_stb && full_c && !word[EE_BIT]) state_d = ST_DROP;
      ST_DROP: if (wr_stb && word[EE_BIT])                        state_d = ST_PASS;
      default: state_d = ST_PASS;
    endcase

    overflow_d = clear ? 1'b0 : (overflow_q | drop);
    if (clear)                              drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    else                                    drop_cnt_d = drop_cnt_q;
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr_q] <= word;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_PASS;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      hold_act_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      hold_act_q <= hold_act_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign data_out   = data_out_q;
  assign valid      = valid_q;
  assign empty      = empty_c;
  assign full       = full_c;
  assign hold       = ~hold_act_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;
  assign spy_data   = {hold_act_q, word};
  assign spy_dv     = wr_en;

endmodule

// File: tb/tb_gf_input_fifo.sv
// Directed bench for gf_input_fifo with default parameters (depth 512, hold 448/384, EVT_DROP=1).
module tb_gf_input_fifo;

  logic        clock;
  logic        reset;
  logic        ds;
  logic [22:0] data_in;
  logic        read_enable;
  logic        clear;
  logic [22:0] data_out;
  logic        valid;
  logic        empty;
  logic        full;
  logic        hold;
  logic        overflow;
  logic [15:0] drop_count;
  logic [23:0] spy_data;
  logic        spy_dv;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [22:0] exp_q[$];
  logic [22:0] w;

  gf_input_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .ds          (ds),
    .data_in     (data_in),
    .read_enable (read_enable),
    .clear       (clear),
    .data_out    (data_out),
    .valid       (valid),
    .empty       (empty),
    .full        (full),
    .hold        (hold),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .spy_data    (spy_data),
    .spy_dv      (spy_dv)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Raise ds and return just after the third sampling edge (write pending next edge).
  task automatic ds_rise(input logic [22:0] v);
    tick();
    data_in = v;
    ds = 1'b1;
    repeat (3) tick();
  endtask

  task automatic send(input logic [22:0] v);
    ds_rise(v);
    ds = 1'b0;
    repeat (3) tick();
  endtask

  task automatic pop(output logic [22:0] v);
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    v = data_out;
  endtask

  task automatic drain(input string tag, input int n);
    logic [22:0] e;
    read_enable = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      e = exp_q.pop_front();
      check($sformatf("%s_%0d", tag, k), {8'd0, valid, data_out}, {8'd0, 1'b1, e});
    end
    read_enable = 1'b0;
  endtask

  initial begin
    reset = 1'b0; ds = 1'b0; data_in = '0; read_enable = 1'b0; clear = 1'b0;
    repeat (3) tick();
    check("rst_data_out", data_out, 0);
    check("rst_valid", valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_hold", hold, 1);
    check("rst_overflow", overflow, 0);
    check("rst_drop_count", drop_count, 0);
    check("rst_spy_dv", spy_dv, 0);
    check("rst_spy_data", spy_data, 0);
    reset = 1'b1;
    tick();

    // First word: ds sampled at edge N, commit at N+3
    tick();
    data_in = 23'h400001; ds = 1'b1;
    tick(); check("first_empty_n", empty, 1);
    tick(); check("first_empty_n1", empty, 1);
    tick(); check("first_empty_n2", empty, 1);
    check("first_spy_dv", spy_dv, 1);
    check("first_spy_data", spy_data, 24'h400001);
    ds = 1'b0;
    tick(); check("first_empty_n3", empty, 0);
    check("first_spy_dv_after", spy_dv, 0);
    repeat (2) tick();
    pop(w);
    check("first_read", {8'd0, valid, data_out}, {8'd0, 1'b1, 23'h400001});
    check("first_empty_after_read", empty, 1);
    tick();
    check("first_valid_drop", valid, 0);
    check("first_data_hold", data_out, 23'h400001);
    pop(w);
    check("read_empty_valid", valid, 0);
    check("read_empty_data", data_out, 23'h400001);

    // Ordering fill with hold assertion at 448
    for (int i = 0; i < 512; i++) begin
      if (i == 447) begin
        ds_rise(23'(i));
        ds = 1'b0;
        tick(); check("hold_at_448_same_edge", hold, 1);
        tick(); check("hold_at_448_next_edge", hold, 0);
        tick();
      end else begin
        send(23'(i));
      end
      if (i == 510) check("full_at_511", full, 0);
    end
    check("full_at_512", full, 1);
    check("hold_at_512", hold, 0);
    check("empty_at_512", empty, 0);

    // Continuous drain with hold release at 384
    read_enable = 1'b1;
    for (int k = 1; k <= 512; k++) begin
      tick();
      check($sformatf("order_%0d", k), {8'd0, valid, data_out}, {8'd0, 1'b1, 23'(k - 1)});
      if (k == 127) check("hold_at_385", hold, 0);
      if (k == 128) check("hold_at_384_same_edge", hold, 0);
      if (k == 129) check("hold_at_384_next_edge", hold, 1);
    end
    read_enable = 1'b0;
    check("order_empty", empty, 1);
    check("order_full", full, 0);

    // Simultaneous read and write at occupancy 10
    for (int i = 0; i < 10; i++) send(23'h100 + 23'(i));
    ds_rise(23'h200);
    check("rw_spy_dv", spy_dv, 1);
    check("rw_spy_data", spy_data, 24'h000200);
    read_enable = 1'b1;
    ds = 1'b0;
    tick();
    read_enable = 1'b0;
    check("rw_first", {8'd0, valid, data_out}, {8'd0, 1'b1, 23'h100});
    repeat (2) tick();
    for (int i = 1; i < 10; i++) exp_q.push_back(23'h100 + 23'(i));
    exp_q.push_back(23'h200);
    drain("rw", 10);
    check("rw_empty", empty, 1);

    // Overflow handling
    for (int i = 0; i < 512; i++) send(23'(i));
    check("evt_full", full, 1);
    check("evt_overflow_pre", overflow, 0);
    send(23'h400050);
    check("ee_at_full_count", drop_count, 1);
    check("ee_at_full_overflow", overflow, 1);
    pop(w);
    check("evt_pop0", data_out, 0);
    send(23'h000060);
    check("ee_stays_pass", drop_count, 1);
    check("ee_stays_pass_full", full, 1);
    send(23'h000010);
    check("evt_enter_drop", drop_count, 2);
    pop(w); check("evt_pop1", data_out, 1);
    pop(w); check("evt_pop2", data_out, 2);
    ds_rise(23'h000011);
    check("drop_no_spy_dv", spy_dv, 0);
    ds = 1'b0;
    repeat (3) tick();
    send(23'h000012);
    send(23'h000013);
    send(23'h400014);
    check("evt_drop_count", drop_count, 6);
    check("evt_not_full", full, 0);
    check("evt_overflow", overflow, 1);
    send(23'h000030);
    send(23'h400031);
    check("next_evt_count", drop_count, 6);
    check("next_evt_full", full, 1);

    // clear concurrent with a drop
    ds_rise(23'h400070);
    clear = 1'b1;
    ds = 1'b0;
    tick();
    clear = 1'b0;
    check("clear_drop_count", drop_count, 0);
    check("clear_overflow", overflow, 0);
    repeat (2) tick();

    for (int i = 3; i < 512; i++) exp_q.push_back(23'(i));
    exp_q.push_back(23'h000060);
    exp_q.push_back(23'h000030);
    exp_q.push_back(23'h400031);
    drain("evt", 512);
    check("evt_empty", empty, 1);

    // Reset while in DROP
    for (int i = 0; i < 512; i++) send(23'h1000 + 23'(i));
    check("refill_full", full, 1);
    send(23'h000080);
    check("pre_reset_drop", drop_count, 1);
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check("mid_reset_empty", empty, 1);
    check("mid_reset_full", full, 0);
    check("mid_reset_drop_count", drop_count, 0);
    check("mid_reset_overflow", overflow, 0);
    check("mid_reset_hold", hold, 1);
    check("mid_reset_valid", valid, 0);
    check("mid_reset_data_out", data_out, 0);
    tick();
    reset = 1'b1;
    tick();
    send(23'h000090);
    check("post_reset_stored", empty, 0);
    check("post_reset_no_drop", drop_count, 0);
    pop(w);
    check("post_reset_read", {8'd0, valid, data_out}, {8'd0, 1'b1, 23'h000090});
    check("post_reset_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
